// File: rtl/snn_pool1d_timestep_ctrl.sv
// snn_pool1d_timestep_ctrl: per-timestep sequencer for the 1D pooling layer,
// gating one upstream spike frame per timestep, with spike counting and stall watchdog.
module snn_pool1d_timestep_ctrl #(
    parameter int TS_WIDTH       = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [TS_WIDTH-1:0]  num_timesteps,
    input  logic [31:0]          cfg_word,
    output logic                 pool_enable,
    output logic                 pool_config_valid,
    output logic [31:0]          pool_config_data,
    input  logic                 pool_layer_done,
    input  logic                 s_axis_tvalid,
    input  logic [31:0]          s_axis_tdata,
    input  logic                 s_axis_tlast,
    output logic                 s_axis_tready,
    output logic                 ds_tvalid,
    output logic [31:0]          ds_tdata,
    output logic                 ds_tlast,
    input  logic                 ds_tready,
    input  logic                 mon_tvalid,
    input  logic                 mon_tready,
    output logic                 busy,
    output logic                 done,
    output logic                 error_timeout,
    output logic [TS_WIDTH-1:0]  cur_timestep,
    output logic [CNT_WIDTH-1:0] spike_count
);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CONFIG = 3'd1;
    localparam logic [2:0] S_FEED   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    logic [2:0]           r_state;
    logic [TS_WIDTH-1:0]  r_num_ts;
    logic [31:0]          r_cfg;
    logic [TS_WIDTH-1:0]  r_cur_ts;
    logic [CNT_WIDTH-1:0] r_spike_cnt;
    logic                 r_err;
    logic                 r_zero_done;
    logic                 r_ld_prev;
    logic [WD_W-1:0]      r_wdog;

    logic [2:0] w_next;
    logic       w_gate;
    logic       w_accept;
    logic       w_hs;
    logic       w_watch;
    logic       w_timeout;
    logic       w_edge;
    logic       w_last_ts;
    logic       w_mon;

    assign w_gate    = r_state == S_FEED;
    assign w_accept  = (r_state == S_IDLE || r_state == S_ERROR) && start && !abort;
    assign w_hs      = w_gate && s_axis_tvalid && ds_tready;
    assign w_watch   = r_state == S_FEED || r_state == S_WAIT;
    assign w_timeout = w_watch && r_wdog == WD_W'(TIMEOUT_CYCLES);
    assign w_edge    = pool_layer_done && !r_ld_prev;
    assign w_last_ts = r_cur_ts == r_num_ts - TS_WIDTH'(1);
    assign w_mon     = mon_tvalid && mon_tready && busy;

    always_comb begin
        w_next = r_state;
        if (abort)
            w_next = S_IDLE;
        else if (w_timeout)
            w_next = S_ERROR;
        else
            case (r_state)
                S_IDLE, S_ERROR: if (start) w_next = (num_timesteps != '0) ? S_CONFIG : S_IDLE;
                S_CONFIG:        w_next = S_FEED;
                S_FEED:          if (w_hs && s_axis_tlast) w_next = S_WAIT;
                S_WAIT:          if (w_edge) w_next = S_NEXT;
                S_NEXT:          w_next = w_last_ts ? S_FINISH : S_CONFIG;
                default:         w_next = S_IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_num_ts    <= '0;
            r_cfg       <= '0;
            r_cur_ts    <= '0;
            r_spike_cnt <= '0;
            r_err       <= 1'b0;
            r_zero_done <= 1'b0;
            r_ld_prev   <= 1'b0;
            r_wdog      <= '0;
        end else begin
            r_state     <= w_next;
            r_ld_prev   <= pool_layer_done;
            r_zero_done <= w_accept && num_timesteps == '0;
            // Watchdog restarts on any state change (covers entry) and on every accepted beat.
            r_wdog      <= (w_watch && !w_hs && w_next == r_state) ? r_wdog + WD_W'(1) : '0;
            if (w_accept) begin
                r_num_ts    <= num_timesteps;
                r_cfg       <= cfg_word;
                r_cur_ts    <= '0;
                r_spike_cnt <= '0;
                r_err       <= 1'b0;
            end else begin
                if (w_mon && !(&r_spike_cnt))
                    r_spike_cnt <= r_spike_cnt + CNT_WIDTH'(1);
                if (r_state == S_NEXT && !w_last_ts && !abort)
                    r_cur_ts <= r_cur_ts + TS_WIDTH'(1);
                if (w_timeout && !abort)
                    r_err <= 1'b1;
            end
        end
    end

    assign pool_enable       = r_state == S_CONFIG || r_state == S_FEED || r_state == S_WAIT || r_state == S_NEXT;
    assign pool_config_valid = r_state == S_CONFIG;
    assign pool_config_data  = r_cfg;
    assign s_axis_tready     = w_gate && ds_tready;
    assign ds_tvalid         = w_gate && s_axis_tvalid;
    assign ds_tdata          = w_gate ? s_axis_tdata : '0;
    assign ds_tlast          = w_gate && s_axis_tlast;
    assign busy              = !(r_state == S_IDLE || r_state == S_ERROR);
    assign done              = r_state == S_FINISH || r_zero_done;
    assign error_timeout     = r_err;
    assign cur_timestep      = r_cur_ts;
    assign spike_count       = r_spike_cnt;
endmodule

// File: tb/tb_snn_pool1d_timestep_ctrl.sv
// tb_snn_pool1d_timestep_ctrl: scoreboard bench for the pooling timestep sequencer,
// with a run-level reference model producing expected config strobes, beats and done events.
module tb_snn_pool1d_timestep_ctrl;
    localparam int TSW = 16;
    localparam int TO  = 16;
    localparam int CW  = 3;

    typedef struct packed {
        logic           busy;
        logic           err;
        logic [CW-1:0]  sc;
        logic [TSW-1:0] ts;
    } done_t;

    logic clk, rst_n, start, abort;
    logic [TSW-1:0] num_timesteps;
    logic [31:0] cfg_word, pool_config_data, s_axis_tdata, ds_tdata;
    logic pool_enable, pool_config_valid, pool_layer_done;
    logic s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic ds_tvalid, ds_tlast, ds_tready, mon_tvalid, mon_tready;
    logic busy, done, error_timeout;
    logic [TSW-1:0] cur_timestep;
    logic [CW-1:0] spike_count;

    int n_cmp = 0;
    int n_bad = 0;
    int n_cfg = 0;
    logic [47:0] cfg_q[$];
    logic [32:0] beat_q[$];
    done_t       done_q[$];

    snn_pool1d_timestep_ctrl #(.TS_WIDTH(TSW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .num_timesteps(num_timesteps), .cfg_word(cfg_word),
        .pool_enable(pool_enable), .pool_config_valid(pool_config_valid),
        .pool_config_data(pool_config_data), .pool_layer_done(pool_layer_done),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .ds_tvalid(ds_tvalid), .ds_tdata(ds_tdata), .ds_tlast(ds_tlast), .ds_tready(ds_tready),
        .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
        .busy(busy), .done(done), .error_timeout(error_timeout),
        .cur_timestep(cur_timestep), .spike_count(spike_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every DUT-presented event is popped from its queue and compared.
    always @(negedge clk) begin
        if (rst_n) begin
            if (pool_config_valid) begin
                n_cfg++;
                if (cfg_q.size() == 0) chk("cfg_unexpected", 1, 0);
                else chk("cfg_strobe", {cur_timestep, pool_config_data}, cfg_q.pop_front());
                chk("cfg_enable", pool_enable, 1);
            end
            if (ds_tvalid) chk("tready_mirror", s_axis_tready, ds_tready);
            if (ds_tvalid && ds_tready) begin
                if (beat_q.size() == 0) chk("beat_unexpected", 1, 0);
                else chk("beat", {ds_tlast, ds_tdata}, beat_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) chk("done_unexpected", 1, 0);
                else chk("done_state", {busy, error_timeout, spike_count, cur_timestep}, done_q.pop_front());
            end
        end
    end

    // Reference for one run: n timesteps, each one frame then a done edge, mon pulses per frame.
    task automatic run(input int n, input int fixlen, input bit bp, input int mon, input bit sticky, input int abort_t);
        logic [31:0] cfg, d;
        int len, base, tot;
        bit hs;
        cfg  = $urandom;
        base = n_cfg;
        for (int t = 0; t < n && (abort_t < 0 || t <= abort_t); t++) cfg_q.push_back({t[TSW-1:0], cfg});
        tot = n * mon;
        if (abort_t < 0) done_q.push_back('{1'b1, 1'b0, CW'((tot > 7) ? 7 : tot), TSW'(n - 1)});
        num_timesteps = TSW'(n);
        cfg_word = cfg;
        start = 1'b1;
        tick();
        start = 1'b0;
        num_timesteps = TSW'($urandom);
        cfg_word = $urandom;
        chk("err_cleared", error_timeout, 0);
        chk("busy_after_start", busy, 1);
        for (int t = 0; t < n; t++) begin
            if (t == abort_t) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata = $urandom;
                s_axis_tlast = 1'b0;
                ds_tready = 1'b0;
                hs = 1'b0;
                for (int i = 0; i < 50 && !hs; i++) begin
                    @(negedge clk);
                    hs = ds_tvalid;
                end
                chk("abort_feed_reached", hs, 1);
                abort = 1'b1;
                start = 1'b1;
                num_timesteps = 3;
                tick();
                abort = 1'b0;
                start = 1'b0;
                ds_tready = 1'b1;
                chk("abort_idle", busy, 0);
                chk("abort_tready", s_axis_tready, 0);
                chk("abort_enable", pool_enable, 0);
                s_axis_tvalid = 1'b0;
                repeat (4) tick();
                chk("abort_stays_idle", busy, 0);
                return;
            end
            len = fixlen ? fixlen : $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                d = $urandom;
                beat_q.push_back({b == len - 1, d});
                s_axis_tvalid = 1'b1;
                s_axis_tdata = d;
                s_axis_tlast = b == len - 1;
                hs = 1'b0;
                for (int i = 0; i < 100 && !hs; i++) begin
                    ds_tready = bp ? ($urandom % 4 != 0) : 1'b1;
                    @(negedge clk);
                    hs = s_axis_tready;
                    tick();
                end
                chk("beat_handshake", hs, 1);
            end
            s_axis_tvalid = 1'b0;
            s_axis_tlast = 1'b0;
            ds_tready = $urandom;
            chk("cur_ts", cur_timestep, t);
            if (sticky && t == 1) begin
                repeat (8) tick();
                chk("sticky_hold_ts", cur_timestep, 1);
                chk("sticky_hold_cfgs", n_cfg - base, 2);
                chk("sticky_hold_busy", busy, 1);
                pool_layer_done = 1'b0;
                tick();
            end
            for (int k = 0; k < 5; k++) begin
                mon_tvalid = k < mon;
                mon_tready = k < mon;
                tick();
            end
            mon_tvalid = 1'b0;
            mon_tready = 1'b0;
            pool_layer_done = 1'b1;
            tick();
            if (!(sticky && t == 0)) pool_layer_done = 1'b0;
        end
        for (int i = 0; i < 20 && busy; i++) tick();
        chk("run_end_idle", busy, 0);
        chk("run_cfg_count", n_cfg - base, n);
        pool_layer_done = 1'b0;
        tick();
    endtask

    task automatic timeout_test();
        logic [31:0] cfg;
        cfg = $urandom;
        cfg_q.push_back({16'd0, cfg});
        num_timesteps = 2;
        cfg_word = cfg;
        start = 1'b1;
        tick();
        start = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = $urandom;
        s_axis_tlast = 1'b0;
        ds_tready = 1'b0;
        repeat (17) tick();
        chk("to_before_err", error_timeout, 0);
        chk("to_before_busy", busy, 1);
        tick();
        chk("to_err", error_timeout, 1);
        chk("to_enable", pool_enable, 0);
        chk("to_busy", busy, 0);
        chk("to_gate", s_axis_tready, 0);
        s_axis_tvalid = 1'b0;
        ds_tready = 1'b1;
        repeat (3) tick();
        chk("to_sticky", error_timeout, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("to_abort_keeps_err", error_timeout, 1);
        chk("to_abort_idle", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        num_timesteps = 5;
        cfg_word = 32'h1234_5678;
        pool_layer_done = 1'b0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 32'hdead_beef;
        s_axis_tlast = 1'b1;
        ds_tready = 1'b1;
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_enable", pool_enable, 0);
        chk("rst_cfg_valid", pool_config_valid, 0);
        chk("rst_cfg_data", pool_config_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", error_timeout, 0);
        chk("rst_cur_ts", cur_timestep, 0);
        chk("rst_spikes", spike_count, 0);
        chk("rst_gate", {s_axis_tready, ds_tvalid, ds_tlast, ds_tdata}, 0);
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        run(3, 4, 1'b0, 2, 1'b0, -1);
        run(3, 4, 1'b0, 1, 1'b1, -1);
        timeout_test();
        run(1, 3, 1'b0, 1, 1'b0, -1);
        for (int r = 0; r < 3; r++) run(3, 0, 1'b1, 1, 1'b0, -1);
        run(3, 4, 1'b0, 1, 1'b0, 1);
        done_q.push_back('{1'b0, 1'b0, CW'(0), TSW'(0)});
        num_timesteps = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        tick();
        chk("zero_done_pulse", done, 0);
        chk("zero_no_cfg", pool_config_valid, 0);
        run(2, 2, 1'b0, 5, 1'b0, -1);
        repeat (3) tick();
        chk("cfg_q_empty", cfg_q.size(), 0);
        chk("beat_q_empty", beat_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
